gxgy_win: RTL and testbench
===========================

Name: gxgy_win

Overview:
- Sobel 3x3 window generator; the producer side of the gradient unit in pre_i.
- Accepts a raster-order 8-bit luma stream for one BLK_W x BLK_H block and buffers the two previous rows.
- For every interior pixel it emits the 8 neighbour samples, packed as x1/x2/x3, with a one-cycle gxgyrun strobe that drives the gradient stage directly.

Parameters:
- BLK_W, 16, block width in pixels (>=3).
- BLK_H, 16, block height in pixels (>=3).

Ports:
- clk  input  1  clock, all logic on rising edge.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  pixel qualifier; a pixel is accepted on any cycle with in_valid=1.
- in_sof  input  1  first pixel of a block; only meaningful when in_valid=1.
- in_data  input  8  luma sample.
- gxgyrun  output  1  window-valid strobe, one cycle per window.
- x1  output  24  top row: [7:0] left, [15:8] centre, [23:16] right.
- x2  output  16  middle row without centre: [7:0] left, [15:8] right.
- x3  output  24  bottom row, packed as x1.
- out_last  output  1  high together with the final gxgyrun of a block.
- busy  output  1  high while a block is in progress.

Behaviour:
- Reset, checked at clock edge while rst=1:
  - gxgyrun, out_last, busy, x1, x2, x3 all go to 0.
  - Counters clear; state becomes IDLE.
  - Line buffers and column shift registers need no reset.
- States:
  - IDLE: waits for an accepted pixel with in_sof=1. Accepted pixels without sof are ignored.
  - RUN: accepts pixels. Counters col (0..BLK_W-1) and row (0..BLK_H-1) advance only on accepted pixels. col wraps to 0 and row increments at col=BLK_W-1.
  - Acceptance of pixel (BLK_H-1, BLK_W-1) returns the state to IDLE.
  - busy=1 exactly in RUN.
- sof handling:
  - An accepted sof in any state, including mid-block, restarts: that pixel is treated as (0,0) and the state is RUN.
  - The aborted block produces no out_last.
  - Pixels arriving after a block completes are ignored until the next sof.
- Datapath on each accepted pixel p at (row r, col c):
  - top = lb1[c], mid = lb0[c], bot = p.
  - Shift {top,mid,bot} into a 3-column window; the oldest column (c-2) is left, the newest (c) is right.
  - Write lb1[c] <= lb0[c] and lb0[c] <= p.
  - Line buffers are 2 x BLK_W x 8-bit registers.
- Output, when r>=2 and c>=2:
  - On the next edge (latency 1 cycle from acceptance), register:
    - x1 = {top[c], top[c-1], top[c-2]}
    - x2 = {mid[c], mid[c-2]}
    - x3 = {bot[c], bot[c-1], bot[c-2]}
  - Pulse gxgyrun=1 for that cycle.
  - The window is centred on (r-1, c-1). Stale shift-register content from the previous row is flushed by c=2 and never emitted.
- Otherwise gxgyrun=0 and x1/x2/x3 hold their last values.
- Each complete block yields (BLK_W-2)*(BLK_H-2) strobes. No border padding.
- out_last=1 only with the strobe generated by pixel (BLK_H-1, BLK_W-1).
- Bubbles: in_valid gaps stall counters and datapath. The output sequence is independent of gap pattern.
- Simultaneous events: rst dominates sof; sof dominates completion.
- Back-to-back blocks: a sof on the cycle after the last pixel is accepted without any bubble.
- The downstream gradient unit forms gx = left column minus right column and gy = top row minus bottom row (weights 1,2,1). This block does no arithmetic.

Test Plan:
- Horizontal ramp, p(r,c)=c, 16x16:
  - First strobe one cycle after pixel (2,2): x1=24'h020100, x2=16'h0200, x3=24'h020100.
  - Every later x1 equals x3.
- Vertical ramp, p(r,c)=16*r:
  - First window x1=24'h000000, x2=16'h1010, x3=24'h202020.
  - Last window x1=24'hD0D0D0, x3=24'hF0F0F0, with out_last=1.
- Full block with continuous valid:
  - Exactly 196 gxgyrun pulses, none during rows 0-1 or columns 0-1.
  - out_last coincides with pulse 196; busy drops after pixel 255.
- Random in_valid gaps (~40% idle) on a pseudo-random image:
  - x1/x2/x3 sequence matches the gap-free run exactly.
- Restart:
  - sof at pixel 100, then a full block: 196 pulses and a single out_last.
  - A stray pixel without sof afterwards produces nothing.
- Reset mid-RUN:
  - Assert rst for 1 cycle at pixel 150: next cycle all outputs are 0 and busy=0.
  - Subsequent non-sof pixels are ignored; a new sof block produces 196 correct windows.

Source files
------------

// File: rtl/gxgy_win_if.sv
// Bundle of the pixel-input and window-output signals of the Sobel window
// generator.
//   master : pixel producer; drives in_valid/in_sof/in_data and observes the
//            window outputs
//   slave  : the window generator itself
// Signals:
//   in_valid  pixel qualifier
//   in_sof    first pixel of a block (meaningful with in_valid)
//   in_data   8-bit luma sample
//   gxgyrun   one-cycle strobe per emitted 3x3 window
//   x1        top row    {right, centre, left}
//   x2        middle row {right, left}
//   x3        bottom row {right, centre, left}
//   out_last  high with the final strobe of a block
//   busy      block in progress
interface gxgy_win_if;
  logic        in_valid;
  logic        in_sof;
  logic [7:0]  in_data;
  logic        gxgyrun;
  logic [23:0] x1;
  logic [15:0] x2;
  logic [23:0] x3;
  logic        out_last;
  logic        busy;

  modport master (
    output in_valid, in_sof, in_data,
    input  gxgyrun, x1, x2, x3, out_last, busy
  );

  modport slave (
    input  in_valid, in_sof, in_data,
    output gxgyrun, x1, x2, x3, out_last, busy
  );
endinterface

// File: rtl/gxgy_win.sv
// Sobel 3x3 window generator. Takes a raster-order luma stream for one
// BLK_W x BLK_H block, keeps the two previous rows in line buffers and, for
// every interior pixel, emits the 8 neighbours of the window centred one row
// and one column behind the current pixel, with a one-cycle gxgyrun strobe.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  gxgy_win_if.slave: pixel input and window output signals
module gxgy_win #(
  parameter int BLK_W = 16,
  parameter int BLK_H = 16
) (
  input  logic        clk,
  input  logic        rst,
  gxgy_win_if.slave   bus
);

  localparam int CW = (BLK_W > 1) ? $clog2(BLK_W) : 1;
  localparam int RW = (BLK_H > 1) ? $clog2(BLK_H) : 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t          state;
  logic [CW-1:0]   col;
  logic [RW-1:0]   row;
  logic [CW-1:0]   col_eff;
  logic [RW-1:0]   row_eff;
  logic            acc;
  logic            emit;
  logic            last_px;

  logic [7:0]      lb0 [BLK_W];   // previous row
  logic [7:0]      lb1 [BLK_W];   // row before that
  logic [7:0]      top_n;
  logic [7:0]      mid_n;

  // Columns c-1 (m1) and c-2 (m2) of the window; column c comes straight
  // from the line buffers and the input pixel.
  logic [7:0]      top_m1_p0, top_m2_p0;
  logic [7:0]      mid_m1_p0, mid_m2_p0;
  logic [7:0]      bot_m1_p0, bot_m2_p0;

  logic            vld_p1;
  logic            last_p1;
  logic [23:0]     x1_p1;
  logic [15:0]     x2_p1;
  logic [23:0]     x3_p1;

  // A sof pixel is accepted in any state and is always position (0,0).
  always_comb begin
    acc     = bus.in_valid && (bus.in_sof || (state == RUN));
    col_eff = bus.in_sof ? '0 : col;
    row_eff = bus.in_sof ? '0 : row;
    top_n   = lb1[col_eff];
    mid_n   = lb0[col_eff];
    emit    = acc && (row_eff >= RW'(2)) && (col_eff >= CW'(2));
    last_px = acc && !bus.in_sof &&
              (row_eff == RW'(BLK_H - 1)) && (col_eff == CW'(BLK_W - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      col   <= '0;
      row   <= '0;
    end else if (acc) begin
      if (col_eff == CW'(BLK_W - 1)) begin
        col <= '0;
        if (row_eff == RW'(BLK_H - 1)) begin
          row   <= '0;
          state <= IDLE;
        end else begin
          row   <= row_eff + 1'b1;
          state <= RUN;
        end
      end else begin
        col   <= col_eff + 1'b1;
        row   <= row_eff;
        state <= RUN;
      end
    end
  end

  // Stage p0: line buffers and window column shift.
  always_ff @(posedge clk) begin
    if (acc) begin
      lb1[col_eff] <= mid_n;
      lb0[col_eff] <= bus.in_data;
      top_m2_p0    <= top_m1_p0;
      top_m1_p0    <= top_n;
      mid_m2_p0    <= mid_m1_p0;
      mid_m1_p0    <= mid_n;
      bot_m2_p0    <= bot_m1_p0;
      bot_m1_p0    <= bus.in_data;
    end
  end

  // Stage p1: registered window outputs, held between strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      last_p1 <= 1'b0;
      x1_p1   <= '0;
      x2_p1   <= '0;
      x3_p1   <= '0;
    end else begin
      vld_p1  <= emit;
      last_p1 <= last_px;
      if (emit) begin
        x1_p1 <= {top_n, top_m1_p0, top_m2_p0};
        x2_p1 <= {mid_n, mid_m2_p0};
        x3_p1 <= {bus.in_data, bot_m1_p0, bot_m2_p0};
      end
    end
  end

  assign bus.gxgyrun  = vld_p1;
  assign bus.out_last = last_p1;
  assign bus.x1       = x1_p1;
  assign bus.x2       = x2_p1;
  assign bus.x3       = x3_p1;
  assign bus.busy     = (state == RUN);

endmodule

// File: tb/tb_gxgy_win.sv
// Testbench for gxgy_win: directed block streams (ramps, pseudo-random
// images, gaps, restart, reset, back-to-back) with a reference window model.
module tb_gxgy_win;

  localparam int W  = 16;
  localparam int H  = 16;
  localparam int IW = W - 2;
  localparam int NW = (W - 2) * (H - 2);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  gxgy_win_if bus ();

  gxgy_win #(.BLK_W(W), .BLK_H(H)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [23:0] x1;
    logic [15:0] x2;
    logic [23:0] x3;
    logic        last;
    int          r;
    int          c;
  } win_t;

  win_t got[$];
  win_t ref_q[$];
  int   checks = 0;
  int   errors = 0;
  int   drv_r, drv_c, tag_r, tag_c;

  // Coordinates of the pixel accepted at each edge, so a strobe can be
  // attributed to the pixel that produced it.
  always @(posedge clk) begin
    tag_r <= drv_r;
    tag_c <= drv_c;
  end

  always @(negedge clk) begin
    if (bus.gxgyrun === 1'b1)
      got.push_back('{bus.x1, bus.x2, bus.x3, bus.out_last, tag_r, tag_c});
  end

  function automatic logic [7:0] pix(input int mode, input int r, input int c);
    case (mode)
      0:       return 8'(c);
      1:       return 8'(16 * r);
      2:       return 8'(r * 73 + c * 29 + r * c * 7 + 13);
      default: return 8'((r * 5) ^ (c * 47 + 91));
    endcase
  endfunction

  function automatic win_t exp_win(input int mode, input int k);
    win_t w;
    int r, c;
    r = 2 + k / IW;
    c = 2 + k % IW;
    w.x1   = {pix(mode, r-2, c), pix(mode, r-2, c-1), pix(mode, r-2, c-2)};
    w.x2   = {pix(mode, r-1, c), pix(mode, r-1, c-2)};
    w.x3   = {pix(mode, r, c), pix(mode, r, c-1), pix(mode, r, c-2)};
    w.last = (k == NW - 1);
    w.r    = r;
    w.c    = c;
    return w;
  endfunction

  task automatic drive(input logic v, input logic s, input logic [7:0] d,
                       input int r, input int c);
    @(negedge clk);
    bus.in_valid = v;
    bus.in_sof   = s;
    bus.in_data  = d;
    drv_r        = r;
    drv_c        = c;
  endtask

  task automatic flush(input int n);
    repeat (n) drive(1'b0, 1'b0, 8'h00, -1, -1);
  endtask

  // Pixels from..to of an image in raster order; sof on index sof_idx.
  task automatic send_range(input int mode, input int sof_idx, input int from,
                            input int to, input bit gaps);
    int r, c, n;
    for (int idx = from; idx <= to; idx++) begin
      r = idx / W;
      c = idx % W;
      if (gaps) begin
        n = 0;
        while (n < 8 && $urandom_range(0, 99) < 40) begin
          drive(1'b0, 1'b0, 8'h00, -1, -1);
          n++;
        end
      end
      drive(1'b1, idx == sof_idx, pix(mode, r, c), r, c);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_sof   = 1'b0;
    bus.in_data  = 8'h00;
    drv_r = -1;
    drv_c = -1;
    repeat (3) @(negedge clk);
    checks++; if (bus.gxgyrun !== 1'b0)  begin errors++; $display("FAIL rst_gxgyrun got %b expected 0", bus.gxgyrun); end
    checks++; if (bus.out_last !== 1'b0) begin errors++; $display("FAIL rst_out_last got %b expected 0", bus.out_last); end
    checks++; if (bus.busy !== 1'b0)     begin errors++; $display("FAIL rst_busy got %b expected 0", bus.busy); end
    checks++; if (bus.x1 !== 24'h0)      begin errors++; $display("FAIL rst_x1 got %h expected 000000", bus.x1); end
    checks++; if (bus.x2 !== 16'h0)      begin errors++; $display("FAIL rst_x2 got %h expected 0000", bus.x2); end
    checks++; if (bus.x3 !== 24'h0)      begin errors++; $display("FAIL rst_x3 got %h expected 000000", bus.x3); end
    rst = 1'b0;
    flush(2);
  endtask

  task automatic test_hramp;
    int neq, nlast;
    win_t e;
    got.delete();
    send_range(0, 0, 0, W*H-1, 1'b0);
    flush(3);
    checks++;
    if (got.size() != NW) begin errors++; $display("FAIL hramp_count got %0d expected %0d", got.size(), NW); end
    else begin
      checks++;
      if (got[0].x1 !== 24'h020100 || got[0].x2 !== 16'h0200 || got[0].x3 !== 24'h020100 ||
          got[0].r != 2 || got[0].c != 2) begin
        errors++;
        $display("FAIL hramp_first got %h %h %h @%0d,%0d expected 020100 0200 020100 @2,2",
                 got[0].x1, got[0].x2, got[0].x3, got[0].r, got[0].c);
      end
      neq = 0;
      nlast = 0;
      foreach (got[i]) begin
        if (got[i].x1 !== got[i].x3) neq++;
        if (got[i].last === 1'b1) nlast++;
      end
      checks++; if (neq != 0)   begin errors++; $display("FAIL hramp_x1_eq_x3 got %0d differing expected 0", neq); end
      checks++; if (nlast != 1 || got[NW-1].last !== 1'b1) begin
        errors++; $display("FAIL hramp_last got %0d lasts final=%b expected 1 final=1", nlast, got[NW-1].last);
      end
      for (int k = 0; k < NW; k++) begin
        e = exp_win(0, k);
        checks++;
        if (got[k].x1 !== e.x1 || got[k].x2 !== e.x2 || got[k].x3 !== e.x3 ||
            got[k].last !== e.last || got[k].r != e.r || got[k].c != e.c) begin
          errors++;
          $display("FAIL hramp_win%0d got %h %h %h %b @%0d,%0d expected %h %h %h %b @%0d,%0d", k,
                   got[k].x1, got[k].x2, got[k].x3, got[k].last, got[k].r, got[k].c,
                   e.x1, e.x2, e.x3, e.last, e.r, e.c);
        end
      end
    end
  endtask

  task automatic test_vramp;
    got.delete();
    send_range(1, 0, 0, W*H-1, 1'b0);
    flush(3);
    checks++;
    if (got.size() != NW) begin errors++; $display("FAIL vramp_count got %0d expected %0d", got.size(), NW); end
    else begin
      checks++;
      if (got[0].x1 !== 24'h000000 || got[0].x2 !== 16'h1010 || got[0].x3 !== 24'h202020) begin
        errors++;
        $display("FAIL vramp_first got %h %h %h expected 000000 1010 202020", got[0].x1, got[0].x2, got[0].x3);
      end
      checks++;
      if (got[NW-1].x1 !== 24'hD0D0D0 || got[NW-1].x3 !== 24'hF0F0F0 || got[NW-1].last !== 1'b1) begin
        errors++;
        $display("FAIL vramp_last got %h %h last=%b expected D0D0D0 F0F0F0 last=1",
                 got[NW-1].x1, got[NW-1].x3, got[NW-1].last);
      end
      checks++;
      if (got[NW-2].last !== 1'b0) begin errors++; $display("FAIL vramp_early_last got %b expected 0", got[NW-2].last); end
    end
  endtask

  task automatic test_full;
    win_t e;
    got.delete();
    send_range(2, 0, 0, W*H-2, 1'b0);
    checks++;
    if (bus.busy !== 1'b1) begin errors++; $display("FAIL full_busy_run got %b expected 1", bus.busy); end
    send_range(2, -1, W*H-1, W*H-1, 1'b0);
    drive(1'b0, 1'b0, 8'h00, -1, -1);
    checks++;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL full_busy_end got %b expected 0", bus.busy); end
    checks++;
    if (bus.gxgyrun !== 1'b1 || bus.out_last !== 1'b1) begin
      errors++; $display("FAIL full_last_strobe got run=%b last=%b expected 1 1", bus.gxgyrun, bus.out_last);
    end
    flush(3);
    checks++;
    if (got.size() != NW) begin errors++; $display("FAIL full_count got %0d expected %0d", got.size(), NW); end
    else begin
      for (int k = 0; k < NW; k++) begin
        e = exp_win(2, k);
        checks++;
        if (got[k].x1 !== e.x1 || got[k].x2 !== e.x2 || got[k].x3 !== e.x3 ||
            got[k].last !== e.last || got[k].r != e.r || got[k].c != e.c) begin
          errors++;
          $display("FAIL full_win%0d got %h %h %h %b @%0d,%0d expected %h %h %h %b @%0d,%0d", k,
                   got[k].x1, got[k].x2, got[k].x3, got[k].last, got[k].r, got[k].c,
                   e.x1, e.x2, e.x3, e.last, e.r, e.c);
        end
      end
    end
    ref_q = got;
  endtask

  task automatic test_gaps;
    got.delete();
    send_range(2, 0, 0, W*H-1, 1'b1);
    flush(3);
    checks++;
    if (got.size() != NW || ref_q.size() != NW) begin
      errors++; $display("FAIL gaps_count got %0d expected %0d", got.size(), NW);
    end else begin
      for (int k = 0; k < NW; k++) begin
        checks++;
        if (got[k].x1 !== ref_q[k].x1 || got[k].x2 !== ref_q[k].x2 ||
            got[k].x3 !== ref_q[k].x3 || got[k].last !== ref_q[k].last) begin
          errors++;
          $display("FAIL gaps_win%0d got %h %h %h %b expected %h %h %h %b", k,
                   got[k].x1, got[k].x2, got[k].x3, got[k].last,
                   ref_q[k].x1, ref_q[k].x2, ref_q[k].x3, ref_q[k].last);
        end
      end
    end
  endtask

  task automatic test_restart;
    int nlast;
    int base;
    win_t e;
    got.delete();
    // 100 pixels cover rows 2..5 (56 windows) and columns 2,3 of row 6.
    send_range(2, 0, 0, 99, 1'b0);
    send_range(3, 0, 0, W*H-1, 1'b0);
    flush(3);
    base = 58;
    checks++;
    if (got.size() != base + NW) begin
      errors++; $display("FAIL restart_count got %0d expected %0d", got.size(), base + NW);
    end else begin
      nlast = 0;
      foreach (got[i]) if (got[i].last === 1'b1) nlast++;
      checks++; if (nlast != 1) begin errors++; $display("FAIL restart_lasts got %0d expected 1", nlast); end
      for (int k = 0; k < NW; k++) begin
        e = exp_win(3, k);
        checks++;
        if (got[base+k].x1 !== e.x1 || got[base+k].x2 !== e.x2 || got[base+k].x3 !== e.x3 ||
            got[base+k].last !== e.last) begin
          errors++;
          $display("FAIL restart_win%0d got %h %h %h %b expected %h %h %h %b", k,
                   got[base+k].x1, got[base+k].x2, got[base+k].x3, got[base+k].last,
                   e.x1, e.x2, e.x3, e.last);
        end
      end
    end
    got.delete();
    send_range(2, -1, 0, W*H-1, 1'b0);
    flush(3);
    checks++; if (got.size() != 0) begin errors++; $display("FAIL stray_count got %0d expected 0", got.size()); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL stray_busy got %b expected 0", bus.busy); end
  endtask

  task automatic test_back_to_back;
    win_t e;
    got.delete();
    send_range(2, 0, 0, W*H-1, 1'b0);
    send_range(3, 0, 0, W*H-1, 1'b0);
    flush(3);
    checks++;
    if (got.size() != 2 * NW) begin
      errors++; $display("FAIL b2b_count got %0d expected %0d", got.size(), 2 * NW);
    end else begin
      for (int k = 0; k < 2 * NW; k++) begin
        e = exp_win(k < NW ? 2 : 3, k % NW);
        checks++;
        if (got[k].x1 !== e.x1 || got[k].x2 !== e.x2 || got[k].x3 !== e.x3 || got[k].last !== e.last) begin
          errors++;
          $display("FAIL b2b_win%0d got %h %h %h %b expected %h %h %h %b", k,
                   got[k].x1, got[k].x2, got[k].x3, got[k].last, e.x1, e.x2, e.x3, e.last);
        end
      end
    end
  endtask

  task automatic test_reset_mid;
    win_t e;
    send_range(0, 0, 0, 149, 1'b0);
    // Reset together with a valid sof pixel: reset must win.
    @(negedge clk);
    rst          = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_sof   = 1'b1;
    bus.in_data  = 8'h55;
    @(negedge clk);
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_sof   = 1'b0;
    checks++; if (bus.gxgyrun !== 1'b0)  begin errors++; $display("FAIL rmid_gxgyrun got %b expected 0", bus.gxgyrun); end
    checks++; if (bus.out_last !== 1'b0) begin errors++; $display("FAIL rmid_out_last got %b expected 0", bus.out_last); end
    checks++; if (bus.busy !== 1'b0)     begin errors++; $display("FAIL rmid_busy got %b expected 0", bus.busy); end
    checks++; if (bus.x1 !== 24'h0)      begin errors++; $display("FAIL rmid_x1 got %h expected 000000", bus.x1); end
    checks++; if (bus.x2 !== 16'h0)      begin errors++; $display("FAIL rmid_x2 got %h expected 0000", bus.x2); end
    checks++; if (bus.x3 !== 24'h0)      begin errors++; $display("FAIL rmid_x3 got %h expected 000000", bus.x3); end
    got.delete();
    send_range(1, -1, 0, W*H-1, 1'b0);
    flush(3);
    checks++; if (got.size() != 0) begin errors++; $display("FAIL rmid_ignored got %0d expected 0", got.size()); end
    send_range(0, 0, 0, W*H-1, 1'b0);
    flush(3);
    checks++;
    if (got.size() != NW) begin errors++; $display("FAIL rmid_count got %0d expected %0d", got.size(), NW); end
    else begin
      for (int k = 0; k < NW; k++) begin
        e = exp_win(0, k);
        checks++;
        if (got[k].x1 !== e.x1 || got[k].x2 !== e.x2 || got[k].x3 !== e.x3 || got[k].last !== e.last) begin
          errors++;
          $display("FAIL rmid_win%0d got %h %h %h %b expected %h %h %h %b", k,
                   got[k].x1, got[k].x2, got[k].x3, got[k].last, e.x1, e.x2, e.x3, e.last);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_hramp();
    test_vramp();
    test_full();
    test_gaps();
    test_restart();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
